// File: rtl/arb_pkg.sv
// Shared types and helpers for the 32-way round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 32;
  localparam int ID_W    = 5;

  typedef enum logic {IDLE, GRANT} state_e;

  // Bits strictly below id are eligible; id 0 yields an empty mask.
  function automatic logic [NUM_REQ-1:0] low_mask(input logic [ID_W-1:0] id);
    low_mask = (NUM_REQ'(1) << id) - NUM_REQ'(1);
  endfunction
endpackage

// File: rtl/dec32to5.sv
// Leading-one encoder: index of the highest set bit; output is meaningless for a zero input.
module dec32to5 (
  input  logic [31:0] vec_i,
  output logic [4:0]  idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < 32; i++) begin
      if (vec_i[i]) idx_o = 5'(i);
    end
  end
endmodule

// File: rtl/rr_arb32.sv
// 32-requester round-robin arbiter with held grants, owner release and a hold watchdog.
// Handshake: a grant is offered only in IDLE with enable_i high; the owner keeps it while req_i[owner] stays high, until release_i or the watchdog ends it.
module rr_arb32
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 255,
  parameter int HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  output logic               grant_vld_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               timeout_o
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               to_q, to_d;

  logic [NUM_REQ-1:0] masked;
  logic [ID_W-1:0]    id_masked, id_all, win_id;
  logic               win_vld, owner_req, expire;

  assign masked = req_i & low_mask(last_q);

  dec32to5 u_dec_masked (.vec_i(masked), .idx_o(id_masked));
  dec32to5 u_dec_all    (.vec_i(req_i),  .idx_o(id_all));

  // Encoder outputs are only trusted behind their OR-reductions.
  assign win_vld   = |req_i;
  assign win_id    = (|masked) ? id_masked : id_all;
  assign owner_req = req_i[last_q];
  assign expire    = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && win_vld) begin
          state_d = GRANT;
          vld_d   = 1'b1;
          gnt_d   = NUM_REQ'(1) << win_id;
          last_d  = win_id;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (release_i || !owner_req || expire) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          gnt_d   = '0;
          cnt_d   = '0;
          to_d    = expire && !release_i && owner_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      gnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign grant_vld_o = vld_q;
  assign grant_o     = gnt_q;
  assign grant_id_o  = last_q;
  assign timeout_o   = to_q;
endmodule
